// File: rtl/hilf6_pkg.sv
// Shared widths, FSM encoding and popcount helper for the 6-element DAC scheduler.
package hilf6_pkg;

  localparam int unsigned N_ELEM = 6;
  localparam int unsigned SW     = 4;
  localparam int unsigned CW     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [CW-1:0] popcount6(input logic [N_ELEM-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N_ELEM); i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/hilf6_pick.sv
// Combinational argmin/argmax over the masked SFI values; lowest index wins ties.
module hilf6_pick
  import hilf6_pkg::*;
(
  input  logic [N_ELEM*SW-1:0] sfi,
  input  logic [N_ELEM-1:0]    mask,
  input  logic                 find_max,
  output logic [N_ELEM-1:0]    sel_c,
  output logic                 found_c
);

  logic [SW-1:0] best;
  logic [SW-1:0] cur;

  // Strict compare keeps the earliest (lowest-index) candidate on ties.
  always_comb begin
    sel_c   = '0;
    found_c = 1'b0;
    best    = '0;
    cur     = '0;
    for (int i = 0; i < int'(N_ELEM); i++) begin
      cur = sfi[i*SW +: SW];
      if (mask[i] && (!found_c || (find_max ? (cur > best) : (cur < best)))) begin
        best     = cur;
        sel_c    = '0;
        sel_c[i] = 1'b1;
        found_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilf6_elem_sched.sv
// Unit-element scheduler: moves one element per cycle toward the requested count, then commits.
// Optional statistics outputs (tr_cnt, sel_cycles) enabled by HILF6_SCHED_STATS_EN.
module hilf6_elem_sched
  import hilf6_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     code_i,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [SW-1:0]     sfi5,
  input  logic [SW-1:0]     sfi4,
  input  logic [SW-1:0]     sfi3,
  input  logic [SW-1:0]     sfi2,
  input  logic [SW-1:0]     sfi1,
  input  logic [SW-1:0]     sfi0,
  output logic [N_ELEM-1:0] st,
  output logic [N_ELEM-1:0] elem,
  output logic              elem_valid,
  output logic              code_err
`ifdef HILF6_SCHED_STATS_EN
  ,
  output logic [15:0]       tr_cnt,
  output logic [3:0]        sel_cycles
`endif
);

  state_t               state;
  state_t               nxt;
  logic [CW-1:0]        tgt;
  logic [N_ELEM*SW-1:0] snap;
  logic [N_ELEM-1:0]    w;
  logic [CW-1:0]        cnt;
  logic                 load_c;
  logic                 step_c;
  logic                 commit_c;
  logic                 find_max;
  logic [N_ELEM-1:0]    pick_sel;
  logic                 pick_found;

  assign cnt      = popcount6(w);
  assign find_max = cnt > tgt;

  hilf6_pick u_pick (
    .sfi      (snap),
    .mask     (find_max ? w : ~w),
    .find_max (find_max),
    .sel_c    (pick_sel),
    .found_c  (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (code_ready && code_valid) nxt = SELECT;
      SELECT:  if (cnt == tgt) nxt = COMMIT;
      COMMIT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    commit_c = 1'b0;
    case (state)
      IDLE:    load_c   = code_ready && code_valid;
      SELECT:  step_c   = cnt != tgt;
      COMMIT:  commit_c = 1'b1;
      default: ;
    endcase
  end

  // Ready is held low through reset and follows the next state afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_ready <= 1'b0;
      tgt        <= '0;
      snap       <= '0;
      w          <= '0;
      elem       <= '0;
      st         <= '0;
      elem_valid <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      code_ready <= (nxt == IDLE);
      elem_valid <= commit_c;
      st         <= commit_c ? (w & ~elem) : '0;
      if (load_c) begin
        tgt  <= (code_i > CW'(N_ELEM)) ? CW'(N_ELEM) : code_i;
        snap <= {sfi5, sfi4, sfi3, sfi2, sfi1, sfi0};
        w    <= elem;
        if (code_i > CW'(N_ELEM)) code_err <= 1'b1;
      end
      if (step_c && pick_found) w <= w ^ pick_sel;
      if (commit_c) elem <= w;
    end
  end

`ifdef HILF6_SCHED_STATS_EN
  logic [3:0]  sel_run;
  logic [16:0] tr_sum;

  assign tr_sum = {1'b0, tr_cnt} + 17'(popcount6(w & ~elem));

  // Saturating transition counter and per-operation SELECT cycle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tr_cnt     <= '0;
      sel_cycles <= '0;
      sel_run    <= '0;
    end else begin
      if (load_c) sel_run <= '0;
      else if (state == SELECT) sel_run <= sel_run + 4'd1;
      if (commit_c) begin
        sel_cycles <= sel_run;
        tr_cnt     <= tr_sum[16] ? 16'hFFFF : tr_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_hilf6_elem_sched.sv
// Scoreboard bench for hilf6_elem_sched: directed codes, monitor checks elem/st/latency on elem_valid.
module tb_hilf6_elem_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] code_i;
  logic       code_valid;
  logic       code_ready;
  logic [3:0] sfi5, sfi4, sfi3, sfi2, sfi1, sfi0;
  logic [5:0] st;
  logic [5:0] elem;
  logic       elem_valid;
  logic       code_err;
`ifdef HILF6_SCHED_STATS_EN
  logic [15:0] tr_cnt;
  logic [3:0]  sel_cycles;
`endif

  hilf6_elem_sched dut (
    .clk        (clk),
    .rst        (rst),
    .code_i     (code_i),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .sfi5       (sfi5),
    .sfi4       (sfi4),
    .sfi3       (sfi3),
    .sfi2       (sfi2),
    .sfi1       (sfi1),
    .sfi0       (sfi0),
    .st         (st),
    .elem       (elem),
    .elem_valid (elem_valid),
    .code_err   (code_err)
`ifdef HILF6_SCHED_STATS_EN
    ,
    .tr_cnt     (tr_cnt),
    .sel_cycles (sel_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  elem;
    logic [5:0]  st;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  bit          mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every elem_valid must match the oldest expected commit, otherwise st must be idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (elem_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_elem_valid actual=elem %b required=no commit", elem);
        end else begin
          e = q.pop_front();
          chk("elem", 32'(elem), 32'(e.elem));
          chk("st_commit", 32'(st), 32'(e.st));
          chk("latency", cyc, e.due);
        end
      end else begin
        chk("st_idle_zero", 32'(st), 32'd0);
      end
    end
  end

  task automatic set_sfi(input logic [3:0] s5, s4, s3, s2, s1, s0);
    sfi5 = s5; sfi4 = s4; sfi3 = s3; sfi2 = s2; sfi1 = s1; sfi0 = s0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!code_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(code_ready), 32'd1);
  endtask

  // Issue one code, push its expected commit, optionally disturb SFI after acceptance.
  task automatic send(input logic [2:0] c, input logic [5:0] ee, input logic [5:0] es,
                      input int unsigned lat, input bit scramble);
    int n = 0;
    wait_ready();
    code_i     = c;
    code_valid = 1'b1;
    q.push_back('{elem: ee, st: es, due: cyc + 1 + lat});
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    if (scramble) set_sfi(4'd0, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0);
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL commit_timeout actual=pending %0d required=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst        = 1'b1;
    code_i     = '0;
    code_valid = 1'b0;
    set_sfi(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_elem", 32'(elem), 32'd0);
    chk("rst_st", 32'(st), 32'd0);
    chk("rst_elem_valid", 32'(elem_valid), 32'd0);
    chk("rst_code_err", 32'(code_err), 32'd0);
    chk("rst_code_ready", 32'(code_ready), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Fill three elements with all-zero SFI: lowest indices win.
    send(3'd3, 6'b000111, 6'b000111, 5, 1'b0);
    // Same count: one SELECT cycle, nothing moves.
    set_sfi(4'd9, 4'd1, 4'd7, 4'd3, 4'd2, 4'd8);
    send(3'd3, 6'b000111, 6'b000000, 2, 1'b0);
    // Back to empty.
    send(3'd0, 6'b000000, 6'b000000, 5, 1'b0);
    // Smallest SFI first, tie between elements 2 and 4; SFI changed after accept.
    set_sfi(4'd1, 4'd0, 4'd3, 4'd0, 4'd2, 4'd5);
    send(3'd2, 6'b010100, 6'b010100, 4, 1'b1);
`ifdef HILF6_SCHED_STATS_EN
    chk("sel_cycles", 32'(sel_cycles), 32'd3);
    chk("tr_cnt", 32'(tr_cnt), 32'd5);
`endif
    // Fill the rest, then drain all six.
    set_sfi(4'd4, 4'd2, 4'd6, 4'd1, 4'd3, 4'd5);
    send(3'd6, 6'b111111, 6'b101011, 6, 1'b0);
    send(3'd0, 6'b000000, 6'b000000, 8, 1'b0);
    chk("code_err_before", 32'(code_err), 32'd0);
    // Out-of-range code clamps to six and sets the sticky error.
    send(3'd7, 6'b111111, 6'b111111, 8, 1'b0);
    chk("code_err_set", 32'(code_err), 32'd1);
    // Clearing four with equal SFI removes the lowest indices first.
    set_sfi(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    send(3'd2, 6'b110000, 6'b000000, 6, 1'b0);
    chk("code_err_sticky", 32'(code_err), 32'd1);
    send(3'd0, 6'b000000, 6'b000000, 4, 1'b0);

    // Reset in the middle of a SELECT: no commit may appear.
    wait_ready();
    code_i     = 3'd5;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_elem", 32'(elem), 32'd0);
    chk("midrst_st", 32'(st), 32'd0);
    chk("midrst_elem_valid", 32'(elem_valid), 32'd0);
    chk("midrst_code_err", 32'(code_err), 32'd0);
    chk("midrst_code_ready", 32'(code_ready), 32'd0);
    rst = 1'b0;
    wait_ready();
    send(3'd1, 6'b000001, 6'b000001, 3, 1'b0);
    chk("final_elem", 32'(elem), 32'd1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
